// File: rtl/pwu_walker_arbiter_if.sv
// rtl/pwu_walker_arbiter_if.sv - request, result and walker-side signal bundle of the page-walk arbiter
interface pwu_walker_arbiter_if #(
  parameter int NUM_WALKERS = 4,
  parameter int VA_W        = 32,
  parameter int PA_W        = 32,
  parameter int L1_VA_W     = 28
);
  // request / result side
  logic                          flush_i;
  logic [VA_W-1:0]               va_i;
  logic                          va_vld_i;
  logic                          va_rdy_o;
  logic [PA_W-1:0]               pa_o;
  logic                          pa_fault_o;
  logic                          pa_vld_o;
  logic                          pa_rdy_i;
  // walker dispatch / result capture
  logic [VA_W-1:0]               wk_va_o;
  logic [NUM_WALKERS-1:0]        wk_va_vld_o;
  logic [NUM_WALKERS-1:0]        wk_rdy_i;
  logic [NUM_WALKERS-1:0]        wk_stall_i;
  logic [NUM_WALKERS*PA_W-1:0]   wk_pa_i;
  logic [NUM_WALKERS-1:0]        wk_pa_vld_i;
  logic [NUM_WALKERS-1:0]        wk_fault_i;
  logic [NUM_WALKERS-1:0]        wk_pa_rdy_o;
  // shared PW$ / L1 / checker ports
  logic [NUM_WALKERS*VA_W-1:0]    wk_pwc_va_i;
  logic [NUM_WALKERS-1:0]         wk_pwc_vld_i;
  logic [NUM_WALKERS*L1_VA_W-1:0] wk_l1_va_i;
  logic [NUM_WALKERS-1:0]         wk_l1_vld_i;
  logic [NUM_WALKERS*L1_VA_W-1:0] wk_ch_va_i;
  logic [NUM_WALKERS-1:0]         wk_ch_vld_i;
  logic [NUM_WALKERS-1:0]         wk_l1_cancel_i;
  logic [VA_W-1:0]                pw_c_va_o;
  logic                           pw_c_vld_o;
  logic [L1_VA_W-1:0]             l1_va_o;
  logic                           l1_va_vld_o;
  logic [L1_VA_W-1:0]             ch_va_o;
  logic                           ch_va_vld_o;
  logic                           l1_cancel_o;
  // status
  logic                           busy_o;
  logic                           err_o;

  modport master (
    output flush_i, va_i, va_vld_i, pa_rdy_i, wk_rdy_i, wk_stall_i, wk_pa_i, wk_pa_vld_i,
           wk_fault_i, wk_pwc_va_i, wk_pwc_vld_i, wk_l1_va_i, wk_l1_vld_i, wk_ch_va_i,
           wk_ch_vld_i, wk_l1_cancel_i,
    input  va_rdy_o, pa_o, pa_fault_o, pa_vld_o, wk_va_o, wk_va_vld_o, wk_pa_rdy_o,
           pw_c_va_o, pw_c_vld_o, l1_va_o, l1_va_vld_o, ch_va_o, ch_va_vld_o, l1_cancel_o,
           busy_o, err_o
  );

  modport slave (
    input  flush_i, va_i, va_vld_i, pa_rdy_i, wk_rdy_i, wk_stall_i, wk_pa_i, wk_pa_vld_i,
           wk_fault_i, wk_pwc_va_i, wk_pwc_vld_i, wk_l1_va_i, wk_l1_vld_i, wk_ch_va_i,
           wk_ch_vld_i, wk_l1_cancel_i,
    output va_rdy_o, pa_o, pa_fault_o, pa_vld_o, wk_va_o, wk_va_vld_o, wk_pa_rdy_o,
           pw_c_va_o, pw_c_vld_o, l1_va_o, l1_va_vld_o, ch_va_o, ch_va_vld_o, l1_cancel_o,
           busy_o, err_o
  );
endinterface

// File: rtl/pwu_walker_arbiter.sv
// rtl/pwu_walker_arbiter.sv - round-robin walker dispatch, shared-port tag pipe and in-order result FIFO
module pwu_walker_arbiter #(
  parameter int NUM_WALKERS  = 4,
  parameter int VA_W         = 32,
  parameter int PA_W         = 32,
  parameter int L1_VA_W      = 28,
  parameter int PWC_STAGE    = 0,
  parameter int L1_STAGE     = 2,
  parameter int CANCEL_STAGE = 3,
  parameter int OUT_STAGE    = 5,
  parameter int RES_DEPTH    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pwu_walker_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_WALKERS);
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(RES_DEPTH);
  localparam logic [NUM_WALKERS-1:0] ONE_W   = NUM_WALKERS'(1);

  logic [SEL_W-1:0]   sel;
  logic [OUT_STAGE:0] tag_v;
  logic [SEL_W-1:0]   tag_sel [OUT_STAGE+1];
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PA_W-1:0]    fifo_pa [RES_DEPTH];
  logic [RES_DEPTH-1:0] fifo_fault;
  logic               err_q;

  logic               run;
  logic               stall;
  logic               va_rdy;
  logic               accept;
  logic               capture;
  logic               cap_vld;
  logic               pop;
  logic               pa_vld;
  logic [SEL_W-1:0]   cap_w;

  // per-walker views of the flattened buses
  logic [PA_W-1:0]    wk_pa     [NUM_WALKERS];
  logic [VA_W-1:0]    wk_pwc_va [NUM_WALKERS];
  logic [L1_VA_W-1:0] wk_l1_va  [NUM_WALKERS];
  logic [L1_VA_W-1:0] wk_ch_va  [NUM_WALKERS];

  for (genvar g = 0; g < NUM_WALKERS; g++) begin : g_unpack
    assign wk_pa[g]     = bus.wk_pa_i[g*PA_W +: PA_W];
    assign wk_pwc_va[g] = bus.wk_pwc_va_i[g*VA_W +: VA_W];
    assign wk_l1_va[g]  = bus.wk_l1_va_i[g*L1_VA_W +: L1_VA_W];
    assign wk_ch_va[g]  = bus.wk_ch_va_i[g*L1_VA_W +: L1_VA_W];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // any walker stalling freezes the whole tag pipe and blocks new dispatch
  assign stall   = |bus.wk_stall_i;
  assign va_rdy  = bus.wk_rdy_i[sel] & ~stall & (cnt < DEPTH_C) & ~bus.flush_i;
  assign accept  = bus.va_vld_i & va_rdy;
  assign cap_w   = tag_sel[OUT_STAGE];
  assign capture = ~stall & tag_v[OUT_STAGE] & ~bus.flush_i;
  assign cap_vld = bus.wk_pa_vld_i[cap_w];
  assign pa_vld  = (fifo_cnt != '0);
  assign pop     = pa_vld & bus.pa_rdy_i;

  // combinational outputs are forced low while reset is asserted
  assign run             = ~rst_i;
  assign bus.va_rdy_o    = run & va_rdy;
  assign bus.wk_va_o     = run ? bus.va_i : '0;
  assign bus.wk_va_vld_o = (run && accept) ? (ONE_W << sel) : '0;
  assign bus.wk_pa_rdy_o = (run && capture) ? (ONE_W << cap_w) : '0;

  assign bus.pw_c_va_o   = run ? wk_pwc_va[tag_sel[PWC_STAGE]] : '0;
  assign bus.pw_c_vld_o  = run & tag_v[PWC_STAGE] & bus.wk_pwc_vld_i[tag_sel[PWC_STAGE]];
  assign bus.l1_va_o     = run ? wk_l1_va[tag_sel[L1_STAGE]] : '0;
  assign bus.l1_va_vld_o = run & tag_v[L1_STAGE] & bus.wk_l1_vld_i[tag_sel[L1_STAGE]];
  assign bus.ch_va_o     = run ? wk_ch_va[tag_sel[L1_STAGE]] : '0;
  assign bus.ch_va_vld_o = run & tag_v[L1_STAGE] & bus.wk_ch_vld_i[tag_sel[L1_STAGE]];
  assign bus.l1_cancel_o = run & tag_v[CANCEL_STAGE] & bus.wk_l1_cancel_i[tag_sel[CANCEL_STAGE]];

  assign bus.pa_vld_o    = pa_vld;
  assign bus.pa_o        = fifo_pa[rd_ptr];
  assign bus.pa_fault_o  = fifo_fault[rd_ptr];
  assign bus.busy_o      = (cnt != '0);
  assign bus.err_o       = err_q;

  // round-robin pointer and walker-tag pipe; the pipe only moves when no walker stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel   <= '0;
      tag_v <= '0;
      for (int i = 0; i <= OUT_STAGE; i++) tag_sel[i] <= '0;
    end else if (bus.flush_i) begin
      sel   <= '0;
      tag_v <= '0;
    end else begin
      if (accept) sel <= sel + 1'b1;
      if (!stall) begin
        tag_v      <= {tag_v[OUT_STAGE-1:0], accept};
        tag_sel[0] <= sel;
        for (int i = 1; i <= OUT_STAGE; i++) tag_sel[i] <= tag_sel[i-1];
      end
    end
  end

  // result FIFO; a missing walker result is stored as a faulting zero PA
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      fifo_fault <= '0;
      for (int i = 0; i < RES_DEPTH; i++) fifo_pa[i] <= '0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (capture) begin
        fifo_pa[wr_ptr]    <= cap_vld ? wk_pa[cap_w] : '0;
        fifo_fault[wr_ptr] <= cap_vld ? bus.wk_fault_i[cap_w] : 1'b1;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // outstanding-translation credits bound the FIFO so it can never overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (bus.flush_i) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // sticky protocol error, survives flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (capture && !cap_vld) begin
      err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pwu_walker_arbiter.sv
// tb/tb_pwu_walker_arbiter.sv - directed self-checking bench for pwu_walker_arbiter
module tb_pwu_walker_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwu_walker_arbiter_if #(.NUM_WALKERS(4), .VA_W(32), .PA_W(32), .L1_VA_W(28)) bus ();

  pwu_walker_arbiter #(
    .NUM_WALKERS(4), .VA_W(32), .PA_W(32), .L1_VA_W(28), .PWC_STAGE(0), .L1_STAGE(2),
    .CANCEL_STAGE(3), .OUT_STAGE(5), .RES_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // walker model: each walker queues its VAs and answers with VA ^ walker index
  logic [31:0] wmem [4][8];
  int          wwr [4];
  int          wrd [4];

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (rst || bus.flush_i) begin
        wwr[w] <= 0;
        wrd[w] <= 0;
      end else begin
        if (bus.wk_va_vld_o[w]) begin
          wmem[w][wwr[w] % 8] <= bus.wk_va_o;
          wwr[w] <= wwr[w] + 1;
        end
        if (bus.wk_pa_rdy_o[w]) wrd[w] <= wrd[w] + 1;
      end
    end
  end

  always_comb begin
    bus.wk_pa_i = '0;
    for (int w = 0; w < 4; w++) bus.wk_pa_i[w*32 +: 32] = wmem[w][wrd[w] % 8] ^ 32'(w);
  end

  // scoreboard of expected results in issue order
  logic [32:0] exp_q [$];
  int          exp_sel  = 0;
  int          acc_cnt  = 0;
  logic [3:0]  bad_mask = 4'b0000;

  task automatic step();
    logic [3:0]  oh;
    logic [32:0] e;
    #1;
    if (bus.va_vld_i && bus.va_rdy_o) begin
      oh = 4'b0001 << exp_sel;
      chk("dispatch", bus.wk_va_vld_o, oh);
      if (bad_mask[exp_sel]) exp_q.push_back({1'b1, 32'h0});
      else exp_q.push_back({1'b0, bus.va_i ^ 32'(exp_sel)});
      exp_sel = (exp_sel + 1) % 4;
      acc_cnt++;
    end
    if (bus.pa_vld_o && bus.pa_rdy_i) begin
      if (exp_q.size() == 0) chk("unexpected_pa", {bus.pa_fault_o, bus.pa_o}, 33'h1_dead_beef);
      else begin
        e = exp_q.pop_front();
        chk("result", {bus.pa_fault_o, bus.pa_o}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.va_vld_i = 1'b0;
    bus.pa_rdy_i = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
    #1;
    chk({tag, "_idle"}, {bus.pa_vld_o, bus.busy_o}, 2'b00);
  endtask

  task automatic stream(input int n, input int stall_after, input logic [31:0] base);
    int         first_acc  = -1;
    int         first_pa   = -1;
    int         stall_left = 0;
    bit         stall_done = 0;
    int         start      = acc_cnt;
    int         i          = 0;
    logic [28:0] l1_hold;
    bus.pa_rdy_i = 1'b1;
    while (((acc_cnt - start) < n || exp_q.size() != 0) && i < 200) begin
      if (stall_after >= 0 && !stall_done && (acc_cnt - start) == stall_after) begin
        stall_left = 3;
        stall_done = 1;
      end
      bus.va_vld_i   = (acc_cnt - start) < n;
      bus.va_i       = base + 32'(acc_cnt - start) * 32'h0104_0011;
      bus.wk_stall_i = (stall_left > 0) ? 4'b0100 : 4'b0000;
      #1;
      if (stall_left > 0) begin
        chk("stall_rdy", bus.va_rdy_o, 0);
        chk("stall_cap", bus.wk_pa_rdy_o, 0);
        if (stall_left == 3) l1_hold = {bus.l1_va_vld_o, bus.l1_va_o};
        else chk("stall_l1", {bus.l1_va_vld_o, bus.l1_va_o}, l1_hold);
        stall_left--;
      end
      if (first_acc < 0 && bus.va_vld_i && bus.va_rdy_o) first_acc = i;
      if (first_pa < 0 && bus.pa_vld_o) first_pa = i;
      step();
      i++;
    end
    bus.wk_stall_i = 4'b0000;
    bus.va_vld_i   = 1'b0;
    chk("stream_acc", acc_cnt - start, n);
    chk("stream_left", exp_q.size(), 0);
    if (stall_after < 0) chk("latency", first_pa - first_acc, 7);
  endtask

  initial begin
    int start;
    bus.flush_i        = 1'b0;
    bus.va_i           = '0;
    bus.va_vld_i       = 1'b1;
    bus.pa_rdy_i       = 1'b1;
    bus.wk_rdy_i       = 4'hF;
    bus.wk_stall_i     = 4'h0;
    bus.wk_pa_vld_i    = 4'hF;
    bus.wk_fault_i     = 4'h0;
    bus.wk_pwc_vld_i   = 4'hF;
    bus.wk_l1_vld_i    = 4'hF;
    bus.wk_ch_vld_i    = 4'hF;
    bus.wk_l1_cancel_i = 4'h0;
    for (int w = 0; w < 4; w++) begin
      bus.wk_pwc_va_i[w*32 +: 32] = 32'hC000_0000 | 32'(w);
      bus.wk_l1_va_i[w*28 +: 28]  = 28'h110_0000 + 28'(w);
      bus.wk_ch_va_i[w*28 +: 28]  = 28'h220_0000 + 28'(w);
    end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", bus.va_rdy_o, 0);
    chk("rst_disp", bus.wk_va_vld_o, 0);
    chk("rst_out", {bus.pa_vld_o, bus.pa_fault_o, bus.pa_o}, 0);
    chk("rst_status", {bus.busy_o, bus.err_o, bus.wk_pa_rdy_o}, 0);
    bus.va_vld_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // shared-port muxing: walker 0 then walker 1 issued back to back
    bus.wk_pwc_vld_i   = 4'b0001;
    bus.wk_l1_vld_i    = 4'b0010;
    bus.wk_ch_vld_i    = 4'b0010;
    bus.wk_l1_cancel_i = 4'b0001;
    bus.va_vld_i = 1'b1;
    bus.va_i     = 32'h0000_1230;
    #1 chk("mux_rdy", bus.va_rdy_o, 1);
    step();
    bus.va_i = 32'h0000_4560;
    #1 chk("pwc_w0", {bus.pw_c_vld_o, bus.pw_c_va_o}, 33'h1_C000_0000);
    chk("l1_empty", bus.l1_va_vld_o, 0);
    step();
    bus.va_vld_i = 1'b0;
    #1 chk("pwc_gated", bus.pw_c_vld_o, 0);
    step();
    #1 chk("l1_w0_gated", {bus.l1_va_vld_o, bus.l1_va_o}, 29'h0110_0000);
    step();
    #1 chk("l1_w1", {bus.l1_va_vld_o, bus.l1_va_o}, 29'h1110_0001);
    chk("ch_w1", {bus.ch_va_vld_o, bus.ch_va_o}, 29'h1220_0001);
    chk("cancel_w0", bus.l1_cancel_o, 1);
    chk("pwc_idle", bus.pw_c_vld_o, 0);
    step();
    drain("mux_drain");
    bus.wk_pwc_vld_i   = 4'hF;
    bus.wk_l1_vld_i    = 4'hF;
    bus.wk_ch_vld_i    = 4'hF;
    bus.wk_l1_cancel_i = 4'h0;

    // back-to-back stream and latency
    stream(8, -1, 32'h1000_0000);

    // stall mid-stream
    stream(8, 3, 32'h2000_0000);

    // backpressure: only RES_DEPTH translations may be outstanding
    bus.pa_rdy_i = 1'b0;
    start = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      bus.va_vld_i = (acc_cnt - start) < 6;
      bus.va_i     = 32'h5000_0000 + 32'(acc_cnt - start);
      step();
    end
    chk("bp_accepted", acc_cnt - start, 4);
    #1 chk("bp_rdy", bus.va_rdy_o, 0);
    chk("bp_full", {bus.pa_vld_o, bus.busy_o}, 2'b11);
    chk("bp_head", {bus.pa_fault_o, bus.pa_o}, exp_q[0]);
    drain("bp_drain");

    // protocol error on walker 2
    chk("err_clear", bus.err_o, 0);
    bad_mask        = 4'b0100;
    bus.wk_pa_vld_i = ~bad_mask;
    stream(4, -1, 32'h6000_0000);
    chk("err_set", bus.err_o, 1);
    bad_mask        = 4'b0000;
    bus.wk_pa_vld_i = 4'hF;
    stream(2, -1, 32'h7000_0000);
    chk("err_sticky", bus.err_o, 1);

    // flush with one queued and three in flight
    bus.pa_rdy_i = 1'b0;
    start = acc_cnt;
    for (int i = 0; i < 7; i++) begin
      bus.va_vld_i = (acc_cnt - start) < 4;
      bus.va_i     = 32'h8000_0000 + 32'(acc_cnt - start);
      step();
    end
    bus.va_vld_i = 1'b0;
    #1 chk("fl_queued", {bus.pa_vld_o, bus.busy_o}, 2'b11);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    exp_q.delete();
    exp_sel = 0;
    #1 chk("fl_empty", {bus.pa_vld_o, bus.busy_o}, 2'b00);
    chk("fl_err_kept", bus.err_o, 1);
    bus.pa_rdy_i = 1'b1;
    repeat (10) step();
    bus.va_vld_i = 1'b1;
    bus.va_i     = 32'h9000_0000;
    bus.flush_i  = 1'b1;
    #1 chk("fl_block", bus.va_rdy_o, 0);
    step();
    bus.flush_i = 1'b0;
    #1 chk("fl_sel0", bus.wk_va_vld_o, 4'b0001);
    step();
    drain("fl_drain");

    // asynchronous reset in the middle of a walk
    bus.va_vld_i = 1'b1;
    bus.va_i     = 32'hA000_0000;
    step();
    step();
    bus.va_vld_i = 1'b0;
    step();
    chk("pre_rst_busy", bus.busy_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_status", {bus.busy_o, bus.err_o, bus.pa_vld_o}, 0);
    chk("arst_ports", {bus.va_rdy_o, bus.l1_va_vld_o, bus.pw_c_vld_o, bus.l1_cancel_o}, 0);
    chk("arst_wk_va", bus.wk_va_o, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_sel = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
